// File: rtl/can_rx_destuff.sv
// CAN receive-path bit destuffer with stuff-rule checking and CRC-15 accumulation.
// Sits between the bit-timing sampler and the frame decoder; all outputs except crc_ok are registered.
module can_rx_destuff #(
    parameter int unsigned STUFF_LIMIT = 5,
    parameter logic [14:0] CRC_POLY    = 15'h4599
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_point,
    input  logic        sampled_bit,
    input  logic        stuff_en,
    input  logic        crc_en,
    input  logic        restart,
    output logic        bit_valid,
    output logic        bit_out,
    output logic        stuff_bit,
    output logic        stuff_err,
    output logic [14:0] crc,
    output logic        crc_ok
);

    localparam int unsigned RW = $clog2(STUFF_LIMIT + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(STUFF_LIMIT);

    logic [RW-1:0] run_len;
    logic          last_bit;
    logic [14:0]   crc_upd;

    always_comb begin
        crc_upd = {crc[13:0], 1'b0} ^ ((sampled_bit ^ crc[14]) ? CRC_POLY : '0);
    end

    assign crc_ok = (crc == '0);

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            run_len   <= '0;
            last_bit  <= 1'b1;
            crc       <= '0;
            stuff_err <= 1'b0;
            bit_valid <= 1'b0;
            bit_out   <= 1'b0;
            stuff_bit <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            stuff_bit <= 1'b0;
            if (sample_point) begin
                if (!stuff_en) begin
                    bit_valid <= 1'b1;
                    bit_out   <= sampled_bit;
                    run_len   <= '0;
                    last_bit  <= sampled_bit;
                    if (crc_en) crc <= crc_upd;
                end else if (!stuff_err) begin
                    if (run_len == RUN_MAX) begin
                        // The removed stuff bit opens the next run, so run_len restarts at 1.
                        if (sampled_bit == last_bit) begin
                            stuff_err <= 1'b1;
                        end else begin
                            stuff_bit <= 1'b1;
                            last_bit  <= sampled_bit;
                            run_len   <= RW'(1);
                        end
                    end else begin
                        bit_valid <= 1'b1;
                        bit_out   <= sampled_bit;
                        last_bit  <= sampled_bit;
                        if (run_len != '0 && sampled_bit == last_bit)
                            run_len <= run_len + RW'(1);
                        else
                            run_len <= RW'(1);
                        if (crc_en) crc <= crc_upd;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_can_rx_destuff.sv
// Directed self-checking bench for can_rx_destuff: stuffing, stuff errors, CRC-15, pass-through,
// restart/reset aborts and back-to-back sample strobes.
module tb_can_rx_destuff;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_point = 1'b0;
    logic        sampled_bit = 1'b1;
    logic        stuff_en = 1'b0;
    logic        crc_en = 1'b0;
    logic        restart = 1'b0;
    logic        bit_valid, bit_out, stuff_bit, stuff_err, crc_ok;
    logic [14:0] crc;

    int checks = 0;
    int errors = 0;

    can_rx_destuff #(.STUFF_LIMIT(5), .CRC_POLY(15'h4599)) dut (
        .clk(clk), .rst(rst), .sample_point(sample_point), .sampled_bit(sampled_bit),
        .stuff_en(stuff_en), .crc_en(crc_en), .restart(restart),
        .bit_valid(bit_valid), .bit_out(bit_out), .stuff_bit(stuff_bit),
        .stuff_err(stuff_err), .crc(crc), .crc_ok(crc_ok)
    );

    always #5 clk = ~clk;

    // One isolated sample strobe; returns on the falling edge after the capturing rising edge.
    task automatic send_bit(input logic b);
        @(negedge clk);
        sample_point = 1'b1;
        sampled_bit  = b;
        @(negedge clk);
        sample_point = 1'b0;
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (bit_valid !== 1'b0) begin errors++; $display("FAIL reset_bit_valid got %b want 0", bit_valid); end
        checks++; if (bit_out !== 1'b0) begin errors++; $display("FAIL reset_bit_out got %b want 0", bit_out); end
        checks++; if (stuff_bit !== 1'b0) begin errors++; $display("FAIL reset_stuff_bit got %b want 0", stuff_bit); end
        checks++; if (stuff_err !== 1'b0) begin errors++; $display("FAIL reset_stuff_err got %b want 0", stuff_err); end
        checks++; if (crc !== 15'h0) begin errors++; $display("FAIL reset_crc got %h want 0000", crc); end
        checks++; if (crc_ok !== 1'b1) begin errors++; $display("FAIL reset_crc_ok got %b want 1", crc_ok); end
    endtask

    task automatic test_stuff_error();
        do_restart();
        stuff_en = 1'b1; crc_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b0);
            checks++; if (bit_valid !== 1'b1 || bit_out !== 1'b0 || stuff_bit !== 1'b0) begin
                errors++; $display("FAIL err_data%0d got v=%b o=%b s=%b want v=1 o=0 s=0", i, bit_valid, bit_out, stuff_bit);
            end
        end
        send_bit(1'b0);
        checks++; if (stuff_err !== 1'b1 || bit_valid !== 1'b0 || stuff_bit !== 1'b0) begin
            errors++; $display("FAIL err_sixth got e=%b v=%b s=%b want e=1 v=0 s=0", stuff_err, bit_valid, stuff_bit);
        end
        for (int i = 0; i < 10; i++) begin
            send_bit(i[0]);
            checks++; if (stuff_err !== 1'b1 || bit_valid !== 1'b0 || stuff_bit !== 1'b0) begin
                errors++; $display("FAIL err_sticky%0d got e=%b v=%b s=%b want e=1 v=0 s=0", i, stuff_err, bit_valid, stuff_bit);
            end
        end
        do_restart();
        checks++; if (stuff_err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b want 0", stuff_err); end
    endtask

    task automatic test_stuff_bit();
        do_restart();
        stuff_en = 1'b1; crc_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b0);
            checks++; if (bit_valid !== 1'b1 || bit_out !== 1'b0) begin
                errors++; $display("FAIL sb_data0_%0d got v=%b o=%b want v=1 o=0", i, bit_valid, bit_out);
            end
        end
        send_bit(1'b1);
        checks++; if (stuff_bit !== 1'b1 || bit_valid !== 1'b0 || stuff_err !== 1'b0) begin
            errors++; $display("FAIL sb_strobe got s=%b v=%b e=%b want s=1 v=0 e=0", stuff_bit, bit_valid, stuff_err);
        end
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b1);
            checks++; if (bit_valid !== 1'b1 || bit_out !== 1'b1 || stuff_bit !== 1'b0) begin
                errors++; $display("FAIL sb_data1_%0d got v=%b o=%b s=%b want v=1 o=1 s=0", i, bit_valid, bit_out, stuff_bit);
            end
        end
        send_bit(1'b1);
        checks++; if (stuff_err !== 1'b1 || bit_valid !== 1'b0) begin
            errors++; $display("FAIL sb_run_err got e=%b v=%b want e=1 v=0", stuff_err, bit_valid);
        end
    endtask

    task automatic test_crc();
        logic [14:0] field;
        do_restart();
        stuff_en = 1'b1; crc_en = 1'b1;
        send_bit(1'b1);
        checks++; if (crc !== 15'h4599 || crc_ok !== 1'b0) begin
            errors++; $display("FAIL crc_first got %h ok=%b want 4599 ok=0", crc, crc_ok);
        end
        send_bit(1'b0);
        checks++; if (crc !== 15'h4EAB) begin errors++; $display("FAIL crc_second got %h want 4eab", crc); end
        field = 15'h4EAB;
        for (int i = 14; i >= 0; i--) send_bit(field[i]);
        checks++; if (crc !== 15'h0 || crc_ok !== 1'b1) begin
            errors++; $display("FAIL crc_residue got %h ok=%b want 0000 ok=1", crc, crc_ok);
        end
        checks++; if (stuff_err !== 1'b0) begin errors++; $display("FAIL crc_no_err got %b want 0", stuff_err); end
        crc_en = 1'b0;
    endtask

    task automatic test_passthrough();
        do_restart();
        stuff_en = 1'b0; crc_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b0);
            checks++; if (bit_valid !== 1'b1 || bit_out !== 1'b0 || stuff_bit !== 1'b0 || stuff_err !== 1'b0) begin
                errors++; $display("FAIL pass%0d got v=%b o=%b s=%b e=%b want v=1 o=0 s=0 e=0",
                                    i, bit_valid, bit_out, stuff_bit, stuff_err);
            end
        end
        stuff_en = 1'b1;
    endtask

    task automatic test_restart_midrun();
        do_restart();
        stuff_en = 1'b1; crc_en = 1'b1;
        send_bit(1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        checks++; if (crc === 15'h0) begin errors++; $display("FAIL rs_pre_crc got %h want nonzero", crc); end
        @(negedge clk);
        sample_point = 1'b1; sampled_bit = 1'b0; restart = 1'b1;
        @(negedge clk);
        sample_point = 1'b0; restart = 1'b0;
        checks++; if (bit_valid !== 1'b0 || stuff_bit !== 1'b0 || crc !== 15'h0) begin
            errors++; $display("FAIL rs_abort got v=%b s=%b crc=%h want v=0 s=0 crc=0000", bit_valid, stuff_bit, crc);
        end
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b0);
            checks++; if (bit_valid !== 1'b1 || stuff_err !== 1'b0) begin
                errors++; $display("FAIL rs_fresh%0d got v=%b e=%b want v=1 e=0", i, bit_valid, stuff_err);
            end
        end
        send_bit(1'b0);
        checks++; if (stuff_err !== 1'b1 || bit_valid !== 1'b0) begin
            errors++; $display("FAIL rs_sixth got e=%b v=%b want e=1 v=0", stuff_err, bit_valid);
        end
        crc_en = 1'b0;
    endtask

    task automatic test_reset_midframe();
        do_restart();
        stuff_en = 1'b1; crc_en = 1'b1;
        send_bit(1'b1);
        for (int i = 0; i < 6; i++) send_bit(1'b0);
        checks++; if (stuff_err !== 1'b1 || crc === 15'h0) begin
            errors++; $display("FAIL rst_pre got e=%b crc=%h want e=1 crc nonzero", stuff_err, crc);
        end
        @(negedge clk);
        rst = 1'b1; sample_point = 1'b1; sampled_bit = 1'b1; stuff_en = 1'b0;
        @(negedge clk);
        rst = 1'b0; sample_point = 1'b0;
        checks++; if (bit_valid !== 1'b0 || bit_out !== 1'b0 || stuff_bit !== 1'b0 || stuff_err !== 1'b0
                      || crc !== 15'h0 || crc_ok !== 1'b1) begin
            errors++; $display("FAIL rst_mid got v=%b o=%b s=%b e=%b crc=%h ok=%b want 0 0 0 0 0000 1",
                                bit_valid, bit_out, stuff_bit, stuff_err, crc, crc_ok);
        end
        stuff_en = 1'b1; crc_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [6:0] bits;
        logic [6:0] exp_v;
        logic [6:0] exp_s;
        bits  = 7'b0100000;  // sent LSB first: 0,0,0,0,0,1(stuff),0
        exp_v = 7'b1011111;
        exp_s = 7'b0100000;
        do_restart();
        stuff_en = 1'b1; crc_en = 1'b0;
        @(negedge clk);
        sample_point = 1'b1;
        sampled_bit  = bits[0];
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i < 6) sampled_bit = bits[i+1];
            else sample_point = 1'b0;
            checks++; if (bit_valid !== exp_v[i] || stuff_bit !== exp_s[i] || stuff_err !== 1'b0
                          || (exp_v[i] && bit_out !== bits[i])) begin
                errors++; $display("FAIL b2b%0d got v=%b s=%b o=%b e=%b want v=%b s=%b o=%b e=0",
                                    i, bit_valid, stuff_bit, bit_out, stuff_err, exp_v[i], exp_s[i], bits[i]);
            end
        end
        @(negedge clk);
        checks++; if (bit_valid !== 1'b0 || stuff_bit !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got v=%b s=%b want 0 0", bit_valid, stuff_bit);
        end
    endtask

    initial begin
        test_reset();
        test_stuff_error();
        test_stuff_bit();
        test_crc();
        test_passthrough();
        test_restart_midrun();
        test_reset_midframe();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
